// File: rtl/br_ram_rd_flow_adapter.sv
// Credit-throttled read adapter: issues reads to a fixed-latency flop RAM and
// buffers the returning data in a small FIFO presented as a ready/valid stream.
module br_ram_rd_flow_adapter #(
    parameter int Depth       = 2,
    parameter int Width       = 1,
    parameter int ReadLatency = 0,
    parameter int BufferDepth = ReadLatency + 2,
    localparam int AddressWidth = $clog2(Depth),
    localparam int CountWidth   = $clog2(BufferDepth + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [AddressWidth-1:0] req_addr,
    output logic                    ram_rd_addr_valid,
    output logic [AddressWidth-1:0] ram_rd_addr,
    input  logic                    ram_rd_data_valid,
    input  logic [Width-1:0]        ram_rd_data,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [Width-1:0]        resp_data,
    output logic [CountWidth-1:0]   credits
);

    localparam int PtrWidth = (BufferDepth > 1) ? $clog2(BufferDepth) : 1;

    logic [CountWidth-1:0] credits_q;
    logic [CountWidth-1:0] occ_q;
    logic [PtrWidth-1:0]   wr_ptr;
    logic [PtrWidth-1:0]   rd_ptr;
    logic [Width-1:0]      mem [BufferDepth];

    logic issue;
    logic push;
    logic pop;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(BufferDepth - 1)) ? '0 : p + PtrWidth'(1);
    endfunction

    // Ready depends only on registered credits so there is no comb path
    // from resp_ready to req_ready.
    assign req_ready         = !rst && (credits_q != '0);
    assign issue             = req_valid && req_ready;
    assign ram_rd_addr_valid = issue;
    assign ram_rd_addr       = req_addr;

    assign push       = ram_rd_data_valid;
    assign resp_valid = !rst && (occ_q != '0);
    assign pop        = resp_valid && resp_ready;
    assign resp_data  = mem[rd_ptr];
    assign credits    = credits_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            credits_q <= CountWidth'(BufferDepth);
            occ_q     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            credits_q <= credits_q - CountWidth'(issue) + CountWidth'(pop);
            occ_q     <= occ_q + CountWidth'(push) - CountWidth'(pop);
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        end
    end

    // Storage needs no reset: occupancy alone qualifies the head.
    always_ff @(posedge clk) begin
        if (push && !rst) mem[wr_ptr] <= ram_rd_data;
    end

`ifndef SYNTHESIS
    logic [CountWidth-1:0] inflight_q;
    logic [ReadLatency:0]  vld_pipe;

    assign vld_pipe[0] = issue;
    if (ReadLatency > 0) begin : g_vld_pipe
        always_ff @(posedge clk) begin
            if (rst) vld_pipe[ReadLatency:1] <= '0;
            else     vld_pipe[ReadLatency:1] <= vld_pipe[ReadLatency-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) inflight_q <= '0;
        else     inflight_q <= inflight_q + CountWidth'(issue) - CountWidth'(push);
    end

    a_rd_latency: assert property (@(posedge clk) disable iff (rst)
        ram_rd_data_valid == vld_pipe[ReadLatency]);
    a_no_orphan_data: assert property (@(posedge clk) disable iff (rst)
        ram_rd_data_valid |-> (inflight_q != '0) || (ReadLatency == 0 && issue));
    a_req_hold: assert property (@(posedge clk) disable iff (rst)
        (req_valid && !req_ready) |=> (req_valid && $stable(req_addr)));
    a_addr_range: assert property (@(posedge clk) disable iff (rst)
        req_valid |-> (int'(req_addr) < Depth));
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        push |-> (int'(occ_q) < BufferDepth));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        pop |-> (occ_q != '0));
    a_credit_max: assert property (@(posedge clk) disable iff (rst)
        int'(credits_q) <= BufferDepth);
    a_credit_balance: assert property (@(posedge clk) disable iff (rst)
        int'(occ_q) + int'(inflight_q) == BufferDepth - int'(credits_q));
`endif

endmodule

// File: tb/tb_br_ram_rd_flow_adapter.sv
// Directed + randomized bench for br_ram_rd_flow_adapter with a latency-2 RAM
// model and a queue-based reference of the expected response stream.
module tb_br_ram_rd_flow_adapter;
    localparam int DEPTH = 16;
    localparam int W     = 8;
    localparam int RL    = 2;
    localparam int BD    = 5;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(BD + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          ram_rd_addr_valid;
    logic [AW-1:0] ram_rd_addr;
    logic          ram_rd_data_valid;
    logic [W-1:0]  ram_rd_data;
    logic          resp_valid;
    logic          resp_ready;
    logic [W-1:0]  resp_data;
    logic [CW-1:0] credits;

    br_ram_rd_flow_adapter #(
        .Depth(DEPTH), .Width(W), .ReadLatency(RL), .BufferDepth(BD)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .ram_rd_addr_valid(ram_rd_addr_valid), .ram_rd_addr(ram_rd_addr),
        .ram_rd_data_valid(ram_rd_data_valid), .ram_rd_data(ram_rd_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .credits(credits)
    );

    always #5 clk = ~clk;

    // RAM read port: fixed latency RL, pipeline cleared by the shared reset.
    logic [W-1:0] ram [DEPTH];
    logic [RL:1]  pv;
    logic [W-1:0] pd [1:RL];
    always @(posedge clk) begin
        if (rst) pv <= '0;
        else begin
            pv[1] <= ram_rd_addr_valid;
            pd[1] <= ram[ram_rd_addr];
            for (int k = 2; k <= RL; k++) begin
                pv[k] <= pv[k-1];
                pd[k] <= pd[k-1];
            end
        end
    end
    assign ram_rd_data_valid = pv[RL];
    assign ram_rd_data       = pd[RL];

    // Reference: every accepted read becomes visible RL+1 cycles later, in order;
    // free credits = BD - accepted + popped since reset.
    typedef struct { logic [W-1:0] d; int vis; } exp_t;
    exp_t q[$];
    int cyc = 0, n_acc = 0, n_pop = 0, n_issue = 0;
    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input logic rv, input logic [AW-1:0] ra, input logic rr,
                        input logic do_rst, output logic acc);
        logic ev, pop;
        req_valid = rv; req_addr = ra; resp_ready = rr;
        #1;
        ev  = (q.size() != 0) && (q[0].vis <= cyc);
        acc = rv && ((n_acc - n_pop) < BD);
        pop = ev && rr;
        chk("credits", 32'(credits), 32'(BD - (n_acc - n_pop)));
        chk("req_ready", 32'(req_ready), 32'((n_acc - n_pop) < BD));
        chk("resp_valid", 32'(resp_valid), 32'(ev));
        if (ev) chk("resp_data", 32'(resp_data), 32'(q[0].d));
        chk("rd_addr_valid", 32'(ram_rd_addr_valid), 32'(acc));
        if (acc) chk("rd_addr", 32'(ram_rd_addr), 32'(ra));
        if (ram_rd_addr_valid) n_issue++;
        if (do_rst) begin
            rst = 1'b1;
            #1;
            chk("rst_req_ready", 32'(req_ready), 32'(0));
            chk("rst_resp_valid", 32'(resp_valid), 32'(0));
            chk("rst_addr_valid", 32'(ram_rd_addr_valid), 32'(0));
            q.delete(); n_acc = 0; n_pop = 0; acc = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back('{ram[ra], cyc + RL + 1});
            n_acc += int'(acc);
            n_pop += int'(pop);
        end
        cyc++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic          acc, rv;
    logic [AW-1:0] ra;
    int            base, tot;

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = W'($urandom);
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
        @(negedge clk); #1;
        chk("reset_req_ready", 32'(req_ready), 32'(0));
        chk("reset_resp_valid", 32'(resp_valid), 32'(0));
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back reads with a free-running consumer.
        base = n_issue;
        for (int i = 0; i < DEPTH; i++) step(1'b1, AW'(i), 1'b1, 1'b0, acc);
        chk("stream_accepts", 32'(n_issue - base), 32'(DEPTH));
        repeat (RL + 3) step(1'b0, '0, 1'b1, 1'b0, acc);

        // Stalled consumer: exactly BD accepts, then a single pop frees one credit.
        base = n_issue; ra = AW'(3);
        repeat (BD + 3) begin
            step(1'b1, ra, 1'b0, 1'b0, acc);
            if (acc) ra++;
        end
        chk("bp_accepts", 32'(n_issue - base), 32'(BD));
        chk("bp_credits", 32'(credits), 32'(0));
        step(1'b1, ra, 1'b1, 1'b0, acc);   // pop with credits at 0: no accept
        step(1'b1, ra, 1'b0, 1'b0, acc);   // freed credit usable now
        if (acc) ra++;
        chk("bp_extra_accept", 32'(n_issue - base), 32'(BD + 1));
        repeat (BD + RL + 3) step(1'b0, '0, 1'b1, 1'b0, acc);

        // Reset with reads in flight and data buffered.
        step(1'b1, AW'(1), 1'b0, 1'b0, acc);
        step(1'b1, AW'(2), 1'b0, 1'b0, acc);
        step(1'b1, AW'(4), 1'b0, 1'b0, acc);
        step(1'b0, '0, 1'b0, 1'b1, acc);
        chk("post_rst_credits", 32'(credits), 32'(BD));
        step(1'b1, AW'(9), 1'b1, 1'b0, acc);
        repeat (RL + 3) step(1'b0, '0, 1'b1, 1'b0, acc);

        // Random traffic, request held until accepted, consumer ready ~50%.
        rv = 1'b0; ra = '0; tot = 0;
        for (int c = 0; c < 4000 && !(tot >= 200 && !rv); c++) begin
            step(rv, ra, 1'($urandom_range(0, 1)), 1'b0, acc);
            if (acc) tot++;
            if (!rv || acc) begin
                rv = (tot < 200) && ($urandom_range(0, 9) < 7);
                ra = AW'($urandom_range(0, DEPTH - 1));
            end
        end
        chk("random_completed", 32'(tot), 32'(200));
        repeat (BD + RL + 4) step(1'b0, '0, 1'b1, 1'b0, acc);

        chk("end_resp_valid", 32'(resp_valid), 32'(0));
        chk("end_credits", 32'(credits), 32'(BD));
        chk("end_scoreboard_empty", 32'(q.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
